dvi_timing_gen: RTL
===================

# dvi_timing_gen

Parametrised video timing generator. It replaces the fixed-mode sync counter and the hard-wired one-cycle sync/DE delay in the DVI top level. It produces pixel coordinates and a pixel request for the image source. It also produces hsync/vsync/DE/start-of-frame, delayed by a configurable pipeline depth so they arrive at the TMDS encoders aligned with the colour data. It runs in the pixel clock domain and adds a frame-boundary-safe start/stop control.

## Interface
Parameters:
- H_ACTIVE, 640: visible pixels per line.
- H_FRONT, 16: horizontal front porch (pixels).
- H_SYNC, 96: hsync width (pixels).
- H_BACK, 48: horizontal back porch (pixels).
- V_ACTIVE, 480: visible lines.
- V_FRONT, 10: vertical front porch (lines).
- V_SYNC, 2: vsync width (lines).
- V_BACK, 33: vertical back porch (lines).
- HSYNC_POL, 0: hsync active level (0 = active-low).
- VSYNC_POL, 0: vsync active level.
- PIPE_DELAY, 1: delay of hsync/vsync/DE/SOF relative to x/y/req. Legal range 0..8.
- X_POS_W, 10: x width. Must satisfy 2^X_POS_W ≥ H_TOTAL.
- Y_POS_W, 10: y width. Must satisfy 2^Y_POS_W ≥ V_TOTAL.

Ports:
- clk_i, in, 1: pixel clock.
- rst_ni, in, 1: reset. One clock; reset is synchronous and active-low.
- en_i, in, 1: run request. Stop takes effect only at a frame boundary.
- x_o, out, X_POS_W: horizontal counter h_cnt.
- y_o, out, Y_POS_W: vertical counter v_cnt.
- req_o, out, 1: pixel (x_o, y_o) is visible; the source must present its colour PIPE_DELAY cycles later.
- hsync_o, out, 1: delayed hsync, polarity per HSYNC_POL.
- vsync_o, out, 1: delayed vsync, polarity per VSYNC_POL.
- de_o, out, 1: delayed data enable.
- sof_o, out, 1: delayed one-cycle pulse at pixel (0,0).
- running_o, out, 1: state ≠ IDLE.

## Operation
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK; V_TOTAL is defined likewise.
- Line order is active, front, sync, back. Frame order is the same, in lines.
- State machine:
  - IDLE: counters held at 0.
    - en_i=1 → RUN.
  - RUN: h_cnt increments every cycle. At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments. At V_TOTAL-1, v_cnt wraps to 0.
    - en_i=0 → DRAIN.
  - DRAIN: counts exactly as RUN.
    - en_i=1 → RUN with no disturbance to the counters.
    - At (H_TOTAL-1, V_TOTAL-1) → IDLE, counters 0.
  - Frames are therefore never truncated.
- Raw decode is combinational from the counters and is forced inactive in IDLE:
  - raw_de = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - raw_hs = h_cnt in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1].
  - raw_vs = v_cnt in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC-1], asserted for whole lines.
  - raw_sof = (h_cnt==0 && v_cnt==0).
- req_o = raw_de, undelayed.
- The PIPE_DELAY-stage shift register carries {raw_hs, raw_vs, raw_de, raw_sof}.
  - Polarity is applied at the output: hsync_o = raw_hs_d ^ ~HSYNC_POL; vsync_o is formed likewise.
  - PIPE_DELAY=0: the outputs are the combinational decode.
- Counter arithmetic uses X_POS_W/Y_POS_W bits. No value ≥ H_TOTAL/V_TOTAL is ever produced.

## Timing
- Reset (rst_ni=0 at a clock edge), values on the next cycle:
  - State IDLE; x_o=0, y_o=0; req_o=0, running_o=0.
  - All delay stages cleared to inactive.
  - de_o=0, sof_o=0.
  - hsync_o=~HSYNC_POL, vsync_o=~VSYNC_POL.
- Reset mid-frame aborts immediately. There is no drain on reset.
- Start: en_i sampled 1 in IDLE at edge N → RUN from edge N. In cycle N+1, x=0, y=0, req_o=1, running_o=1.
- de_o/sof_o/syncs lag the corresponding req_o/counter values by exactly PIPE_DELAY cycles.
- Stop: en_i low for any length during a frame → last counted pixel is (H_TOTAL-1, V_TOTAL-1). running_o falls the cycle after it. The delay line still drains its last PIPE_DELAY entries after that.
- en_i toggling within a frame has no visible effect on the outputs.
- Steady state: sof_o period = H_TOTAL·V_TOTAL cycles. de_o high H_ACTIVE·V_ACTIVE cycles per frame.

## Test plan
Bench parameters: H 4/1/2/1 (H_TOTAL=8), V 3/1/1/1 (V_TOTAL=6), PIPE_DELAY=2, HSYNC_POL=VSYNC_POL=0.
- Reset, then en_i=1 → cycle 1: x=0, y=0, req=1. Cycle 3: de_o=1, sof_o=1. hsync_o low only at delayed x=5,6. Frame period 48 cycles.
- Count per frame → 12 de_o cycles. vsync_o low for exactly 8 consecutive cycles, starting at delayed (0,4).
- en_i=0 at (2,1) → counting continues to (7,5), then x=y=0 and running_o=0. No new sof_o.
- en_i dropped at (2,1) and raised at (3,3) → uninterrupted frames with no gap in the sof_o period.
- rst_ni=0 at (3,2) → next cycle all outputs equal their reset values, including mid-delay entries. Restart behaves as in the first scenario.
- Re-run with PIPE_DELAY=0 and HSYNC_POL=1 → de_o==req_o, and hsync_o is high at x=5,6.

Source files
------------

// File: rtl/dvi_timing_gen.sv
// ---------------------------------------------------------------------------
// dvi_timing_gen
//
// Parametrised video timing generator for the DVI output path. Walks a pixel
// raster (active, front porch, sync, back porch, both horizontally and
// vertically), hands pixel coordinates plus a pixel request to the image
// source, and emits hsync/vsync/DE/start-of-frame delayed by PIPE_DELAY
// cycles so that they reach the TMDS encoders aligned with the colour data.
// Stopping is deferred to the end of the current frame so that frames are
// never truncated.
//
// Ports:
//   clk_i      - pixel clock
//   rst_ni     - synchronous active-low reset
//   en_i       - run request; deasserting it stops at the next frame boundary
//   x_o        - current horizontal position (h_cnt)
//   y_o        - current vertical position (v_cnt)
//   req_o      - (x_o, y_o) is visible; colour expected PIPE_DELAY cycles on
//   hsync_o    - delayed hsync, active level HSYNC_POL
//   vsync_o    - delayed vsync, active level VSYNC_POL
//   de_o       - delayed data enable
//   sof_o      - delayed one-cycle pulse at pixel (0,0)
//   running_o  - generator is not idle
// ---------------------------------------------------------------------------
module dvi_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0,
    parameter int PIPE_DELAY = 1,
    parameter int X_POS_W    = 10,
    parameter int Y_POS_W    = 10
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en_i,
    output logic [X_POS_W-1:0] x_o,
    output logic [Y_POS_W-1:0] y_o,
    output logic               req_o,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               de_o,
    output logic               sof_o,
    output logic               running_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [X_POS_W-1:0] H_LAST   = X_POS_W'(H_TOTAL - 1);
    localparam logic [Y_POS_W-1:0] V_LAST   = Y_POS_W'(V_TOTAL - 1);
    localparam logic [X_POS_W-1:0] H_ACT_C  = X_POS_W'(H_ACTIVE);
    localparam logic [Y_POS_W-1:0] V_ACT_C  = Y_POS_W'(V_ACTIVE);
    localparam logic [X_POS_W-1:0] HS_START = X_POS_W'(H_ACTIVE + H_FRONT);
    localparam logic [X_POS_W-1:0] HS_END   = X_POS_W'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [Y_POS_W-1:0] VS_START = Y_POS_W'(V_ACTIVE + V_FRONT);
    localparam logic [Y_POS_W-1:0] VS_END   = Y_POS_W'(V_ACTIVE + V_FRONT + V_SYNC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state;
    logic [X_POS_W-1:0] h_cnt;
    logic [Y_POS_W-1:0] v_cnt;
    logic [X_POS_W-1:0] h_next;
    logic [Y_POS_W-1:0] v_next;
    logic               h_last;
    logic               v_last;
    logic               frame_last;
    logic               active;

    // Bundle order in the delay line: {hs, vs, de, sof}, all active-high.
    logic [3:0]         raw;
    logic [3:0]         raw_d;

    assign h_last     = (h_cnt == H_LAST);
    assign v_last     = (v_cnt == V_LAST);
    assign frame_last = h_last && v_last;
    assign active     = (state != IDLE);

    // Raster advance: next pixel position with horizontal wrap feeding the
    // line counter, and the line counter wrapping at the end of the frame.
    always_comb begin
        h_next = h_cnt + X_POS_W'(1);
        v_next = v_cnt;
        if (h_last) begin
            h_next = '0;
            v_next = v_last ? '0 : v_cnt + Y_POS_W'(1);
        end
    end

    // Control FSM and raster counters. Leaving IDLE does not advance the
    // counters, so the first running cycle shows pixel (0,0). A stop request
    // only parks the FSM in DRAIN; the counters keep going and the return to
    // IDLE happens on the last pixel of the frame, unless en_i came back
    // first, in which case counting simply carries on.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en_i) begin
                        state <= RUN;
                    end
                end
                RUN, DRAIN: begin
                    if (state == DRAIN && !en_i && frame_last) begin
                        state <= IDLE;
                        h_cnt <= '0;
                        v_cnt <= '0;
                    end else begin
                        state <= en_i ? RUN : DRAIN;
                        h_cnt <= h_next;
                        v_cnt <= v_next;
                    end
                end
                default: begin
                    state <= IDLE;
                    h_cnt <= '0;
                    v_cnt <= '0;
                end
            endcase
        end
    end

    // Undelayed decode of the raster position, forced inactive when idle.
    always_comb begin
        raw    = '0;
        raw[3] = active && (h_cnt >= HS_START) && (h_cnt <= HS_END);
        raw[2] = active && (v_cnt >= VS_START) && (v_cnt <= VS_END);
        raw[1] = active && (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
        raw[0] = active && (h_cnt == '0) && (v_cnt == '0);
    end

    // Alignment delay for the sync/DE/SOF bundle. Reset empties every stage
    // so that no stale sync or DE from an aborted frame leaks out.
    generate
        if (PIPE_DELAY == 0) begin : g_no_delay
            assign raw_d = raw;
        end else begin : g_delay
            logic [3:0] pipe [PIPE_DELAY];

            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    for (int i = 0; i < PIPE_DELAY; i++) begin
                        pipe[i] <= '0;
                    end
                end else begin
                    pipe[0] <= raw;
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        pipe[i] <= pipe[i-1];
                    end
                end
            end

            assign raw_d = pipe[PIPE_DELAY-1];
        end
    endgenerate

    assign x_o       = h_cnt;
    assign y_o       = v_cnt;
    assign req_o     = raw[1];
    assign running_o = active;

    // Polarity is applied only at the pins: an inactive internal sync shows
    // up as the inverse of the active level.
    assign hsync_o = raw_d[3] ^ ~HSYNC_POL;
    assign vsync_o = raw_d[2] ^ ~VSYNC_POL;
    assign de_o    = raw_d[1];
    assign sof_o   = raw_d[0];

endmodule
